// File: rtl/sm_controller.sv
`default_nettype none
// ============================================================================
// Module      : sm_controller
// Description : Instruction register, decoder and Moore sequencer driving the
//               16-bit datapath strobes one cycle per state.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  nsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic        write,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_COMPUTE   = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    localparam logic [2:0] c_nsel_none = 3'b000;
    localparam logic [2:0] c_nsel_rn   = 3'b100;
    localparam logic [2:0] c_nsel_rd   = 3'b010;
    localparam logic [2:0] c_nsel_rm   = 3'b001;
    localparam logic [1:0] c_vsel_c    = 2'b00;
    localparam logic [1:0] c_vsel_imm  = 2'b10;

    function automatic logic f_is_mov_imm(input logic [15:0] ir);
        return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
    endfunction

    function automatic logic f_is_mov_reg(input logic [15:0] ir);
        return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
    endfunction

    function automatic logic f_is_alu(input logic [15:0] ir);
        return ir[15:13] == 3'b101;
    endfunction

    state_t      r_state;
    logic [15:0] r_ir;
    logic        r_w;
    logic [2:0]  r_nsel;
    logic        r_loada, r_loadb, r_loadc, r_loads, r_asel, r_write;
    logic [1:0]  r_vsel, r_aluop;

    state_t      w_state_nxt;
    logic [15:0] w_ir_nxt;
    logic        w_idle_nxt;
    logic [2:0]  w_nsel_nxt;
    logic        w_loada_nxt, w_loadb_nxt, w_loadc_nxt, w_loads_nxt;
    logic        w_asel_nxt, w_write_nxt;
    logic [1:0]  w_vsel_nxt, w_aluop_nxt;
    logic [2:0]  w_regnum;

    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_WAIT: begin
                if (load) w_ir_nxt = in;
                if (s)    w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (f_is_mov_imm(r_ir))
                    w_state_nxt = S_WRITE_IMM;
                else if (f_is_mov_reg(r_ir) || (f_is_alu(r_ir) && r_ir[12:11] == 2'b11))
                    w_state_nxt = S_GET_B;
                else if (f_is_alu(r_ir))
                    w_state_nxt = S_GET_A;
                else
                    w_state_nxt = S_WAIT;
            end
            S_WRITE_IMM: w_state_nxt = S_WAIT;
            S_GET_A:     w_state_nxt = S_GET_B;
            S_GET_B:     w_state_nxt = S_COMPUTE;
            S_COMPUTE: begin
                if (f_is_alu(r_ir) && r_ir[12:11] == 2'b01)
                    w_state_nxt = S_WAIT;
                else
                    w_state_nxt = S_WRITE_REG;
            end
            S_WRITE_REG: w_state_nxt = S_WAIT;
            default:     w_state_nxt = S_WAIT;
        endcase
    end

    // Strobes are decoded for the upcoming state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        w_idle_nxt  = 1'b0;
        w_nsel_nxt  = c_nsel_none;
        w_loada_nxt = 1'b0;
        w_loadb_nxt = 1'b0;
        w_loadc_nxt = 1'b0;
        w_loads_nxt = 1'b0;
        w_asel_nxt  = 1'b0;
        w_vsel_nxt  = c_vsel_c;
        w_write_nxt = 1'b0;
        w_aluop_nxt = w_ir_nxt[12:11];
        case (w_state_nxt)
            S_WAIT:      w_idle_nxt = 1'b1;
            S_WRITE_IMM: begin
                w_nsel_nxt  = c_nsel_rn;
                w_vsel_nxt  = c_vsel_imm;
                w_write_nxt = 1'b1;
            end
            S_GET_A: begin
                w_nsel_nxt  = c_nsel_rn;
                w_loada_nxt = 1'b1;
            end
            S_GET_B: begin
                w_nsel_nxt  = c_nsel_rm;
                w_loadb_nxt = 1'b1;
            end
            S_COMPUTE: begin
                w_loadc_nxt = 1'b1;
                if (f_is_mov_reg(w_ir_nxt)) begin
                    w_aluop_nxt = 2'b00;
                    w_asel_nxt  = 1'b1;
                end
                if (f_is_alu(w_ir_nxt) && w_ir_nxt[12:11] == 2'b01)
                    w_loads_nxt = 1'b1;
            end
            S_WRITE_REG: begin
                w_nsel_nxt  = c_nsel_rd;
                w_write_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
            r_w     <= 1'b1;
            r_nsel  <= c_nsel_none;
            r_loada <= 1'b0;
            r_loadb <= 1'b0;
            r_loadc <= 1'b0;
            r_loads <= 1'b0;
            r_asel  <= 1'b0;
            r_vsel  <= c_vsel_c;
            r_write <= 1'b0;
            r_aluop <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_w     <= w_idle_nxt;
            r_nsel  <= w_nsel_nxt;
            r_loada <= w_loada_nxt;
            r_loadb <= w_loadb_nxt;
            r_loadc <= w_loadc_nxt;
            r_loads <= w_loads_nxt;
            r_asel  <= w_asel_nxt;
            r_vsel  <= w_vsel_nxt;
            r_write <= w_write_nxt;
            r_aluop <= w_aluop_nxt;
        end
    end

    always_comb begin
        case (r_nsel)
            c_nsel_rn: w_regnum = r_ir[10:8];
            c_nsel_rd: w_regnum = r_ir[7:5];
            c_nsel_rm: w_regnum = r_ir[2:0];
            default:   w_regnum = 3'd0;
        endcase
    end

    assign w        = r_w;
    assign nsel     = r_nsel;
    assign readnum  = w_regnum;
    assign writenum = w_regnum;
    assign loada    = r_loada;
    assign loadb    = r_loadb;
    assign loadc    = r_loadc;
    assign loads    = r_loads;
    assign asel     = r_asel;
    assign bsel     = 1'b0;
    assign vsel     = r_vsel;
    assign write    = r_write;
    assign ALUop    = r_aluop;
    assign shift    = r_ir[4:3];
    assign sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};

endmodule
`default_nettype wire

// File: doc/sm_controller.md
# sm_controller

Instruction register, decoder and Moore state machine that sequence the 16-bit datapath: register file, A/B/C pipeline registers, shifter, the 4-operation ALU (add, subtract, AND, NOT-B) and its status register. It accepts one instruction at a time, drives every datapath load, select and write strobe cycle by cycle, and raises `w` when idle. It sits between the top-level switch/key interface and the datapath.

## Interface
- No parameters; datapath width fixed at 16, register file 8 × 16.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `s` in 1: start; sampled only in WAIT.
- `load` in 1: capture `in` into IR; honoured only in WAIT.
- `in` in 16: instruction word.
- `w` out 1: 1 in WAIT (idle, ready for `s`).
- `nsel` out 3: one-hot register-field select: 100=Rn (IR[10:8]), 010=Rd (IR[7:5]), 001=Rm (IR[2:0]), 000=none.
- `readnum`, `writenum` out 3: both equal the field selected by `nsel`; 0 when `nsel`=000.
- `loada`, `loadb`, `loadc`, `loads` out 1: datapath register enables.
- `asel` out 1: 1 forces ALU A input to 0.
- `bsel` out 1: 1 selects `sximm5` for B; always 0 in this instruction set.
- `vsel` out 2: write-back source: 00=C, 10=`sximm8`; 01/11 never driven.
- `write` out 1: register-file write enable.
- `ALUop` out 2: to ALU.
- `shift` out 2: IR[4:3].
- `sximm8` out 16: IR[7:0] sign-extended. `sximm5` out 16: IR[4:0] sign-extended.

## Operation
- IR fields: opcode IR[15:13], op IR[12:11].
- Supported instructions: MOV Rn,#imm8 (110/10); MOV Rd,Rm{,sh} (110/00); ADD Rd,Rn,Rm{,sh} (101/00); CMP Rn,Rm{,sh} (101/01); AND Rd,Rn,Rm{,sh} (101/10); MVN Rd,Rm{,sh} (101/11). All other opcode/op pairs are unsupported.
- States and actions (outputs not listed are 0; `nsel`=000):
  - WAIT: `w`=1. `s`=1 → DECODE; else stay.
  - DECODE: no strobes. MOV imm → WRITE_IMM; MOV reg or MVN → GET_B; ADD/CMP/AND → GET_A; unsupported → WAIT.
  - WRITE_IMM: `nsel`=100, `vsel`=10, `write`=1 → WAIT.
  - GET_A: `nsel`=100, `loada`=1 → GET_B.
  - GET_B: `nsel`=001, `loadb`=1 → COMPUTE.
  - COMPUTE: `loadc`=1; `ALUop`=IR[12:11], except MOV reg forces `ALUop`=00 with `asel`=1 (C = 0 + shifted Rm); CMP additionally `loads`=1. CMP → WAIT; others → WRITE_REG.
  - WRITE_REG: `nsel`=010, `vsel`=00, `write`=1 → WAIT.
- Outside COMPUTE, `ALUop` still equals IR[12:11] (harmless; no strobe). `shift`, `sximm5`, `sximm8` are continuous functions of IR.
- All strobes are Moore outputs: functions of state and IR only, never of `s`, `load` or `in`.

## Timing
- Reset: state=WAIT, IR=16'h0000, `w`=1, all strobes 0, `nsel`=000, `readnum`=`writenum`=0, `sximm8`=`sximm5`=0. Takes effect immediately, including mid-instruction; an interrupted instruction performs no further strobes.
- Latency in cycles with `w`=0 after the edge sampling `s`: MOV imm 2; CMP 4; MOV reg and MVN 4; ADD and AND 5.
- `load` and `s` both high in WAIT at the same edge: IR captures `in` and the state enters DECODE; DECODE uses the new IR.
- `load` outside WAIT is ignored; IR is stable for the whole instruction.
- `s` held high through completion: a new instruction starts at the first edge in WAIT, so `w` is high for exactly one cycle.
- Register-file write lands on the edge ending WRITE_IMM/WRITE_REG. The status register updates on the edge ending COMPUTE for CMP only.

## Test plan
- Reset, then hold `reset`=0 with `s`=0 → `w`=1, all strobes 0, IR=0 and state stays in WAIT indefinitely.
- Load 16'hD0FB (MOV R0,#-5), pulse `s` → DECODE, then WRITE_IMM with `write`=1, `writenum`=0, `vsel`=10, `sximm8`=16'hFFFB → WAIT; `w` low exactly 2 cycles.
- Load 16'hA140 (ADD R2,R1,R0), pulse `s` → GET_A `loada`, `readnum`=1; GET_B `loadb`, `readnum`=0; COMPUTE `loadc`, `ALUop`=00, `loads`=0; WRITE_REG `write`, `writenum`=2, `vsel`=00; `w` low 5 cycles.
- Load 16'hA900 (CMP R1,R0) → COMPUTE has `loadc`=1, `loads`=1, `ALUop`=01; `write` never asserted; `w` low 4 cycles. Load 16'hC069 (MOV R3,R1,LSL#1) → GET_B `readnum`=1, `shift`=01; COMPUTE `asel`=1, `ALUop`=00; write `writenum`=3.
- Assert `load` with a different `in` during GET_A → IR unchanged. Assert `reset` during GET_B of ADD → `w`=1 at once, no `loadc` or `write` follows, and IR=0.
- Load 16'h0000 (unsupported), pulse `s` → DECODE then WAIT with no strobes; `w` low 1 cycle.
